// File: rtl/fifo_read_serializer.sv
// -----------------------------------------------------------------------------
// fifo_read_serializer
//
// Drains a multi-ported FIFO onto a single valid/ready stream. In IDLE it looks
// at how many words the FIFO currently offers, issues one read-enable cycle for
// up to MAX_BURST of them, captures the registered read data one cycle later,
// and then plays the captured words out in port order (port 0 first). Port
// ordering matches the FIFO's rule that port r returns the r-th oldest word.
//
// Ports:
//   clk           - clock, all state on rising edge
//   rst           - asynchronous active-high reset
//   fifo_rd_en    - read enables to the FIFO (contiguous mask from bit 0)
//   fifo_rd_data  - FIFO registered read data, port r at [r*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rd_valid - FIFO per-port availability (port r high when > r words held)
//   m_valid       - output word valid
//   m_ready       - downstream accepts the word
//   m_data        - output word
//   m_first       - first word of a burst
//   m_last        - last word of a burst
//   busy          - high whenever the FSM is not in IDLE
//   word_count    - running count of output handshakes, wraps modulo 2^32
// -----------------------------------------------------------------------------
module fifo_read_serializer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int MAX_BURST      = NUM_READ_PORTS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [NUM_READ_PORTS-1:0]            fifo_rd_en,
    input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [NUM_READ_PORTS-1:0]            fifo_rd_valid,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic                                 m_first,
    output logic                                 m_last,
    output logic                                 busy,
    output logic [31:0]                          word_count
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           burstLen_q, burstLen_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [31:0]             wordCount_q, wordCount_d;

    // Buffer is indexed by port number. Entries at or above MAX_BURST are
    // never loaded and fold away in synthesis; sizing it by port count keeps
    // every read-data lane connected for any legal parameter choice.
    logic [DATA_WIDTH-1:0]   buf_q [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]   buf_d [NUM_READ_PORTS];

    logic [CW-1:0]           runLen;
    logic                    runBroken;
    logic [NUM_READ_PORTS-1:0] rdEn;
    logic [DATA_WIDTH-1:0]   curWord;
    logic                    isLast;
    logic                    inDrain;

    // Length of the unbroken run of available ports starting at port 0,
    // capped at MAX_BURST. Anything above the first gap is ignored so a
    // non-thermometer availability pattern never causes an out-of-order read.
    always_comb begin
        runLen    = '0;
        runBroken = 1'b0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            if (!runBroken && fifo_rd_valid[r] && (r < MAX_BURST)) begin
                runLen = CW'(r + 1);
            end else begin
                runBroken = 1'b1;
            end
        end
    end

    // Select the buffered word currently being presented.
    always_comb begin
        curWord = '0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            if (int'(idx_q) == r) begin
                curWord = buf_q[r];
            end
        end
    end

    assign isLast  = (idx_q == (burstLen_q - CW'(1)));
    assign inDrain = (state_q == DRAIN);

    // Next-state logic. Read enables exist only in IDLE, so every burst gets
    // exactly one read-enable cycle and a stalled DRAIN never pulls more words.
    always_comb begin
        state_d     = state_q;
        burstLen_d  = burstLen_q;
        idx_d       = idx_q;
        wordCount_d = wordCount_q;
        buf_d       = buf_q;
        rdEn        = '0;
        case (state_q)
            IDLE: begin
                if (runLen != '0) begin
                    for (int r = 0; r < NUM_READ_PORTS; r++) begin
                        rdEn[r] = (r < int'(runLen));
                    end
                    burstLen_d = runLen;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // FIFO read registers now hold the words requested last cycle.
                for (int r = 0; r < NUM_READ_PORTS; r++) begin
                    if (r < int'(burstLen_q)) begin
                        buf_d[r] = fifo_rd_data[r*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (m_ready) begin
                    wordCount_d = wordCount_q + 32'd1;
                    if (isLast) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset throws away any partially drained
    // burst; words already pulled from the FIFO are intentionally lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burstLen_q  <= '0;
            idx_q       <= '0;
            wordCount_q <= '0;
            for (int r = 0; r < NUM_READ_PORTS; r++) begin
                buf_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            burstLen_q  <= burstLen_d;
            idx_q       <= idx_d;
            wordCount_q <= wordCount_d;
            buf_q       <= buf_d;
        end
    end

    // Outputs are gated by rst so they drop in the same cycle reset rises,
    // including the combinational read enables that depend on fifo_rd_valid.
    assign fifo_rd_en = rst ? '0 : rdEn;
    assign m_valid    = !rst && inDrain;
    assign m_data     = (!rst && inDrain) ? curWord : '0;
    assign m_first    = !rst && inDrain && (idx_q == '0);
    assign m_last     = !rst && inDrain && isLast;
    assign busy       = !rst && (state_q != IDLE);
    assign word_count = wordCount_q;

endmodule

// File: tb/tb_fifo_read_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_serializer
//
// Self-checking bench for fifo_read_serializer. A two-port, full-burst instance
// is driven from a table of bursts and a few hand-written sequences; a second
// instance with MAX_BURST=1 covers the capped-burst case. Expected output words
// are pushed to a per-instance queue when a burst is issued and popped by a
// monitor whenever the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_fifo_read_serializer;

    logic        clk;
    logic        rst;

    // Full-burst instance
    logic [1:0]  fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic [1:0]  fifo_rd_valid;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_first;
    logic        m_last;
    logic        busy;
    logic [31:0] word_count;

    // MAX_BURST=1 instance
    logic [1:0]  fifo_rd_en1;
    logic [63:0] fifo_rd_data1;
    logic [1:0]  fifo_rd_valid1;
    logic        m_valid1;
    logic        m_ready1;
    logic [31:0] m_data1;
    logic        m_first1;
    logic        m_last1;
    logic        busy1;
    logic [31:0] word_count1;

    int errors = 0;
    int checks = 0;
    int expCount = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    typedef struct {
        logic [1:0]  validPat;
        logic [31:0] laneA;
        logic [31:0] laneB;
        logic [1:0]  expEn;
        int          expLen;
        int          stall;
    } vec_t;

    vec_t vecs[6];

    fifo_read_serializer #(
        .DATA_WIDTH(32),
        .NUM_READ_PORTS(2),
        .MAX_BURST(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_valid(fifo_rd_valid),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_first(m_first),
        .m_last(m_last),
        .busy(busy),
        .word_count(word_count)
    );

    fifo_read_serializer #(
        .DATA_WIDTH(32),
        .NUM_READ_PORTS(2),
        .MAX_BURST(1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .fifo_rd_en(fifo_rd_en1),
        .fifo_rd_data(fifo_rd_data1),
        .fifo_rd_valid(fifo_rd_valid1),
        .m_valid(m_valid1),
        .m_ready(m_ready1),
        .m_data(m_data1),
        .m_first(m_first1),
        .m_last(m_last1),
        .busy(busy1),
        .word_count(word_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            if (sb0.size() == 0) begin
                checkOutput("dut_unexpected_word", m_data, 32'hxxxxxxxx);
            end else begin
                e = sb0.pop_front();
                checkOutput("dut_m_data", m_data, e.data);
                checkOutput("dut_m_first", 32'(m_first), 32'(e.first));
                checkOutput("dut_m_last", 32'(m_last), 32'(e.last));
            end
        end
        if (!rst && m_valid1 && m_ready1) begin
            if (sb1.size() == 0) begin
                checkOutput("dut1_unexpected_word", m_data1, 32'hxxxxxxxx);
            end else begin
                e = sb1.pop_front();
                checkOutput("dut1_m_data", m_data1, e.data);
                checkOutput("dut1_m_first", 32'(m_first1), 32'(e.first));
                checkOutput("dut1_m_last", 32'(m_last1), 32'(e.last));
            end
        end
    end

    // One burst on the full-burst instance: issue, wait, drain with optional
    // stall, then confirm the return to IDLE at the expected cycle.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        fifo_rd_valid = v.validPat;
        fifo_rd_data  = {v.laneB, v.laneA};
        m_ready       = (v.stall == 0);
        @(negedge clk);
        checkOutput("idle_rd_en", 32'(fifo_rd_en), 32'(v.expEn));
        checkOutput("idle_m_valid", 32'(m_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < v.expLen; i++) begin
            e.data  = (i == 0) ? v.laneA : v.laneB;
            e.first = (i == 0);
            e.last  = (i == v.expLen - 1);
            sb0.push_back(e);
        end
        expCount += v.expLen;
        @(posedge clk); #1;
        fifo_rd_valid = 2'b00;
        @(negedge clk);
        if (v.expLen == 0) begin
            checkOutput("noread_busy", 32'(busy), 32'd0);
            checkOutput("noread_rd_en", 32'(fifo_rd_en), 32'd0);
            checkOutput("noread_m_valid", 32'(m_valid), 32'd0);
            return;
        end
        checkOutput("wait_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("wait_m_valid", 32'(m_valid), 32'd0);
        checkOutput("wait_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("drain_m_valid", 32'(m_valid), 32'd1);
        checkOutput("drain_first_data", m_data, v.laneA);
        checkOutput("drain_first_flag", 32'(m_first), 32'd1);
        checkOutput("drain_first_last", 32'(m_last), 32'(v.expLen == 1));
        checkOutput("drain_rd_en", 32'(fifo_rd_en), 32'd0);
        for (int s = 1; s < v.stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("stall_m_valid", 32'(m_valid), 32'd1);
            checkOutput("stall_m_data", m_data, v.laneA);
            checkOutput("stall_m_first", 32'(m_first), 32'd1);
            checkOutput("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        if (v.stall > 0) begin
            @(posedge clk); #1;
            m_ready = 1'b1;
            repeat (v.expLen + 1) @(negedge clk);
        end else begin
            repeat (v.expLen) @(negedge clk);
        end
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_m_valid", 32'(m_valid), 32'd0);
        checkOutput("done_sb_empty", 32'(sb0.size()), 32'd0);
        checkOutput("done_word_count", word_count, 32'(expCount));
    endtask

    initial begin
        exp_t e;

        vecs[0] = '{2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'b11, 2, 0};
        vecs[1] = '{2'b01, 32'h0000_0011, 32'hDEAD_BEEF, 2'b01, 1, 0};
        vecs[2] = '{2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 2, 5};
        vecs[3] = '{2'b10, 32'hCAFE_0001, 32'hCAFE_0002, 2'b00, 0, 0};
        vecs[4] = '{2'b01, 32'h5555_AAAA, 32'h0F0F_0F0F, 2'b01, 1, 2};
        vecs[5] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 2, 1};

        rst            = 1'b1;
        fifo_rd_valid  = 2'b11;
        fifo_rd_data   = '0;
        m_ready        = 1'b0;
        fifo_rd_valid1 = 2'b00;
        fifo_rd_data1  = '0;
        m_ready1       = 1'b1;

        // Outputs must be forced low while reset is held, even with data offered.
        #12;
        checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_m_data", m_data, 32'd0);
        checkOutput("rst_word_count", word_count, 32'd0);

        @(posedge clk); #1;
        fifo_rd_valid = 2'b00;
        rst           = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            checkOutput("empty_m_valid", 32'(m_valid), 32'd0);
            checkOutput("empty_busy", 32'(busy), 32'd0);
            checkOutput("empty_word_count", word_count, 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a burst, just after the first word is taken.
        @(posedge clk); #1;
        fifo_rd_valid = 2'b11;
        fifo_rd_data  = {32'hB0B0_0002, 32'hA0A0_0001};
        m_ready       = 1'b1;
        e = '{32'hA0A0_0001, 1'b1, 1'b0};
        sb0.push_back(e);
        e = '{32'hB0B0_0002, 1'b0, 1'b1};
        sb0.push_back(e);
        @(negedge clk);
        checkOutput("mid_rd_en", 32'(fifo_rd_en), 32'd3);
        @(posedge clk); #1;
        fifo_rd_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mid_second_word_up", m_data, 32'hB0B0_0002);
        rst = 1'b1;
        sb0.delete();
        expCount = 0;
        #1;
        checkOutput("mid_rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_m_data", m_data, 32'd0);
        checkOutput("mid_rst_m_last", 32'(m_last), 32'd0);
        checkOutput("mid_rst_word_count", word_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
            checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);
            checkOutput("post_rst_word_count", word_count, 32'd0);
        end

        // MAX_BURST=1: two words available, but only port 0 may be read per burst.
        @(posedge clk); #1;
        fifo_rd_valid1 = 2'b11;
        fifo_rd_data1  = {32'h2222_0002, 32'h1111_0001};
        e = '{32'h1111_0001, 1'b1, 1'b1};
        sb1.push_back(e);
        @(negedge clk);
        checkOutput("mb1_rd_en_first", 32'(fifo_rd_en1), 32'd1);
        @(posedge clk); #1;
        fifo_rd_valid1 = 2'b01;
        @(negedge clk);
        checkOutput("mb1_wait_rd_en", 32'(fifo_rd_en1), 32'd0);
        checkOutput("mb1_wait_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mb1_drain_valid", 32'(m_valid1), 32'd1);
        checkOutput("mb1_drain_rd_en", 32'(fifo_rd_en1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mb1_rd_en_second", 32'(fifo_rd_en1), 32'd1);
        e = '{32'h2222_0002, 1'b1, 1'b1};
        sb1.push_back(e);
        @(posedge clk); #1;
        fifo_rd_valid1 = 2'b00;
        fifo_rd_data1  = {32'h0000_0000, 32'h2222_0002};
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("mb1_done_busy", 32'(busy1), 32'd0);
        checkOutput("mb1_sb_empty", 32'(sb1.size()), 32'd0);
        checkOutput("mb1_word_count", word_count1, 32'd2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
